addsub_acc_pipe: RTL and testbench

- Parametrised, two-stage pipelined add/subtract/accumulate unit. It is the successor to the fixed 4-bit clocked adder.
- Adds a WIDTH parameter, an operation mode, an internal accumulator, signed overflow, unsigned carry/borrow, and a valid handshake with stall via En.
- Sits between operand registers and the datapath result bus; downstream consumers qualify results with Out_Valid.

---
 rtl/addsub_acc_pipe.sv | 105 ++++++++++
 tb/tb_addsub_acc_pipe.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/addsub_acc_pipe.sv
// Two-stage add/sub/accumulate unit with signed overflow, unsigned carry/borrow and an internal accumulator.
// Latency: operation sampled at edge k shows on Sum/Carry/Overflow/Out_Valid after edge k+1; one result per cycle.
// Backpressure: En=0 freezes every register (including Out_Valid and Acc); In_Valid is ignored while stalled.
// Optional: define ADDSUB_SATURATE_EN to clamp Sum/Acc on signed overflow instead of wrapping.
module addsub_acc_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             In_Valid,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow,
    output logic             Out_Valid,
    output logic [WIDTH-1:0] Acc
);

    localparam int MSB = WIDTH - 1;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;

    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [1:0]       s1_mode;
    logic             s1_v;

    logic [WIDTH-1:0] opx;
    logic [WIDTH-1:0] opy;
    logic [WIDTH:0]   raw;
    logic [WIDTH-1:0] res;
    logic             carry_n;
    logic             ovf_n;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_a    <= '0;
            s1_b    <= '0;
            s1_mode <= 2'b00;
            s1_v    <= 1'b0;
        end else if (En) begin
            s1_a    <= A;
            s1_b    <= B;
            s1_mode <= Mode;
            s1_v    <= In_Valid;
        end
    end

    // Accumulate uses Acc as the left operand and A as the right; Acc is read
    // straight from its register, so back-to-back accumulates chain naturally.
    always_comb begin
        opx     = s1_mode[1] ? Acc : s1_a;
        opy     = s1_mode[1] ? s1_a : s1_b;
        raw     = '0;
        ovf_n   = 1'b0;
        case (s1_mode)
            MODE_ADD, MODE_ACC: begin
                raw   = {1'b0, opx} + {1'b0, opy};
                ovf_n = (opx[MSB] == opy[MSB]) && (raw[MSB] != opx[MSB]);
            end
            MODE_SUB: begin
                raw   = {1'b0, opx} - {1'b0, opy};
                ovf_n = (opx[MSB] != opy[MSB]) && (raw[MSB] != opx[MSB]);
            end
            default: begin
                raw   = '0;
                ovf_n = 1'b0;
            end
        endcase
        carry_n = raw[WIDTH];
        res     = raw[WIDTH-1:0];
`ifdef ADDSUB_SATURATE_EN
        // Overflow direction follows the sign of the left operand.
        if (ovf_n) begin
            res = opx[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Sum       <= '0;
            Carry     <= 1'b0;
            Overflow  <= 1'b0;
            Out_Valid <= 1'b0;
            Acc       <= '0;
        end else if (En) begin
            Out_Valid <= s1_v;
            if (s1_v) begin
                Sum      <= res;
                Carry    <= carry_n;
                Overflow <= ovf_n;
                if (s1_mode[1]) begin
                    Acc <= res;
                end
            end
        end
    end

endmodule

// File: tb/tb_addsub_acc_pipe.sv
// Directed bench for addsub_acc_pipe (WIDTH=8): reset, add/sub flags, accumulate chain, stall, bubble, mid-flight reset.
module tb_addsub_acc_pipe;

    localparam int W = 8;

    logic         Clk;
    logic         Reset;
    logic         En;
    logic         In_Valid;
    logic [1:0]   Mode;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Sum;
    logic         Carry;
    logic         Overflow;
    logic         Out_Valid;
    logic [W-1:0] Acc;

    int n_tests = 0;
    int n_fail  = 0;

    addsub_acc_pipe #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .En        (En),
        .In_Valid  (In_Valid),
        .Mode      (Mode),
        .A         (A),
        .B         (B),
        .Sum       (Sum),
        .Carry     (Carry),
        .Overflow  (Overflow),
        .Out_Valid (Out_Valid),
        .Acc       (Acc)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
        In_Valid = v;
        Mode     = m;
        A        = a;
        B        = b;
    endtask

    // Issue one op, follow with a bubble, then check the result it produced.
    task automatic op_check(input string tag, input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] es, input logic ec, input logic eo);
        drive(1'b1, m, a, b);
        step();
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        step();
        check({tag, ".sum"}, Sum, es);
        check({tag, ".carry"}, Carry, ec);
        check({tag, ".ovf"}, Overflow, eo);
        check({tag, ".vld"}, Out_Valid, 1'b1);
    endtask

    initial begin
        Reset = 1'b1;
        En    = 1'b1;
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        step();
        Reset = 1'b0;
        check("rst.sum", Sum, 0);
        check("rst.carry", Carry, 0);
        check("rst.ovf", Overflow, 0);
        check("rst.vld", Out_Valid, 0);
        check("rst.acc", Acc, 0);

        op_check("add1", 2'b00, 8'h01, 8'h03, 8'h04, 1'b0, 1'b0);
`ifdef ADDSUB_SATURATE_EN
        op_check("addovf", 2'b00, 8'h7F, 8'h01, 8'h7F, 1'b0, 1'b1);
`else
        op_check("addovf", 2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
`endif
        op_check("addcy", 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        op_check("subbr", 2'b01, 8'h02, 8'h05, 8'hFD, 1'b1, 1'b0);
`ifdef ADDSUB_SATURATE_EN
        op_check("subovf", 2'b01, 8'h80, 8'h01, 8'h80, 1'b0, 1'b1);
`else
        op_check("subovf", 2'b01, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
`endif
        check("addsub.acc", Acc, 0);

        // Clear, five accumulates of 0x10, then an interleaved add.
        drive(1'b1, 2'b11, 8'h55, 8'h66);
        step();
        drive(1'b1, 2'b10, 8'h10, 8'h77);
        step();
        check("clr.sum", Sum, 0);
        check("clr.acc", Acc, 0);
        check("clr.vld", Out_Valid, 1);
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) drive(1'b1, 2'b00, 8'h01, 8'h01);
            step();
            check($sformatf("acc%0d.sum", i), Sum, i * 16);
            check($sformatf("acc%0d.acc", i), Acc, i * 16);
            check($sformatf("acc%0d.vld", i), Out_Valid, 1);
            check($sformatf("acc%0d.carry", i), Carry, 0);
        end
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        step();
        check("ileave.sum", Sum, 8'h02);
        check("ileave.acc", Acc, 8'h50);
        check("ileave.vld", Out_Valid, 1);

        // Stall with one result showing and one in stage 1.
        drive(1'b1, 2'b00, 8'h05, 8'h06);
        step();
        drive(1'b1, 2'b00, 8'h07, 8'h01);
        step();
        check("prestall.sum", Sum, 8'h0B);
        En = 1'b0;
        drive(1'b1, 2'b00, 8'hFF, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall%0d.sum", i), Sum, 8'h0B);
            check($sformatf("stall%0d.vld", i), Out_Valid, 1);
            check($sformatf("stall%0d.acc", i), Acc, 8'h50);
            check($sformatf("stall%0d.carry", i), Carry, 0);
        end
        En = 1'b1;
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        step();
        check("unstall.sum", Sum, 8'h08);
        check("unstall.vld", Out_Valid, 1);
        step();
        check("drain.vld", Out_Valid, 0);
        check("drain.sum", Sum, 8'h08);

        // Single bubble between two adds.
        drive(1'b1, 2'b00, 8'h10, 8'h20);
        step();
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        step();
        check("bub.a.sum", Sum, 8'h30);
        check("bub.a.vld", Out_Valid, 1);
        drive(1'b1, 2'b00, 8'h01, 8'h01);
        step();
        check("bub.gap.vld", Out_Valid, 0);
        check("bub.gap.sum", Sum, 8'h30);
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        step();
        check("bub.b.sum", Sum, 8'h02);
        check("bub.b.vld", Out_Valid, 1);

        // Reset with an accumulate in stage 1 and an add at the input.
        drive(1'b1, 2'b10, 8'h03, 8'h00);
        step();
        drive(1'b1, 2'b00, 8'h02, 8'h02);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        check("mrst.sum", Sum, 0);
        check("mrst.acc", Acc, 0);
        check("mrst.vld", Out_Valid, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("mrst%0d.vld", i), Out_Valid, 0);
            check($sformatf("mrst%0d.acc", i), Acc, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
